// File: rtl/fll_freq_meter.sv
// Frequency meter for an FLL output clock: counts synchronized clk_m rising edges
// over a window of num_i reference cycles and flags lock against the expected count.
module fll_freq_meter #(
  parameter int CCW_I = 8,
  parameter int CCW_O = 8,
  parameter int SYN   = 2,
  parameter int TOL   = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clk_m,
  input  logic [CCW_I-1:0] num_i,
  input  logic [CCW_O-1:0] num_o,
  input  logic             start_i,
  output logic             busy_o,
  output logic [CCW_O-1:0] cnt_o,
  output logic             ovf_o,
  output logic             vld_o,
  input  logic             rdy_i,
  output logic             lock_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SYN-1:0]   r_sync;
  logic             r_dly;
  logic             w_edge;
  logic [CCW_I-1:0] r_win;
  logic [CCW_O-1:0] r_exp;
  logic [CCW_O-1:0] r_cnt;
  logic             r_ovf;
  logic             r_vld;
  logic             r_busy;
  logic             r_lock;
  logic [CCW_O-1:0] w_cnt_inc;
  logic             w_ovf_inc;
  logic [CCW_O-1:0] w_fin_cnt;
  logic [CCW_O-1:0] w_fin_exp;
  logic             w_fin_ovf;
  logic [CCW_O:0]   w_diff;
  logic             w_lock_nxt;
  logic             w_last;

  // Edge detection runs in every state so the window never sees a stale edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYN-2:0], clk_m};
      r_dly  <= r_sync[SYN-1];
    end
  end

  assign w_edge = r_sync[SYN-1] & ~r_dly;
  assign w_last = (r_win == CCW_I'(1));

  always_comb begin
    w_cnt_inc = r_cnt;
    w_ovf_inc = r_ovf;
    if (w_edge) begin
      if (r_cnt == '1) w_ovf_inc = 1'b1;
      else             w_cnt_inc = r_cnt + 1'b1;
    end
  end

  // Lock is judged on the value the count will have once HOLD is entered.
  always_comb begin
    w_fin_cnt = w_cnt_inc;
    w_fin_exp = r_exp;
    w_fin_ovf = w_ovf_inc;
    if (r_state == IDLE) begin
      w_fin_cnt = '0;
      w_fin_exp = num_o;
      w_fin_ovf = 1'b0;
    end
    if ({1'b0, w_fin_cnt} >= {1'b0, w_fin_exp}) w_diff = {1'b0, w_fin_cnt} - {1'b0, w_fin_exp};
    else                                        w_diff = {1'b0, w_fin_exp} - {1'b0, w_fin_cnt};
    w_lock_nxt = !w_fin_ovf && (w_diff <= (CCW_O+1)'(TOL));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start_i) w_state_nxt = (num_i == '0) ? HOLD : GATE;
      GATE: if (w_last) w_state_nxt = HOLD;
      HOLD: if (rdy_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_exp   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_win  <= num_i;
            r_exp  <= num_o;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
            if (num_i == '0) begin
              r_vld  <= 1'b1;
              r_lock <= w_lock_nxt;
            end
          end
        end
        GATE: begin
          r_win <= r_win - 1'b1;
          r_cnt <= w_cnt_inc;
          r_ovf <= w_ovf_inc;
          if (w_last) begin
            r_vld  <= 1'b1;
            r_lock <= w_lock_nxt;
          end
        end
        HOLD: begin
          if (rdy_i) begin
            r_vld  <= 1'b0;
            r_busy <= 1'b0;
          end
        end
        default: begin
          r_vld  <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = r_busy;
  assign cnt_o  = r_cnt;
  assign ovf_o  = r_ovf;
  assign vld_o  = r_vld;
  assign lock_o = r_lock;

endmodule
